sccb_config_controller: RTL and testbench

//  Sequences OV7670 register configuration over SCCB (3-phase write) after reset/start.

---
 rtl/sccb_config_controller_if.sv | 12 +
 rtl/sccb_config_controller.sv | 142 ++++++++++++++
 tb/tb_sccb_config_controller.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_config_controller_if.sv
// sccb_config_controller_if: start/status handshake and configuration table bus
interface sccb_config_controller_if #(
    parameter int ROM_ADDR_WIDTH = 8
) ();
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [15:0]               rom_data;
    modport master (input start, rom_data, output busy, done, rom_addr);
    modport slave (output start, rom_data, input busy, done, rom_addr);
endinterface

// File: rtl/sccb_config_controller.sv
// sccb_config_controller: walks a {sub_addr, value} table and writes each entry to an OV7670 over SCCB
module sccb_config_controller #(
    parameter int         CLK_FREQ_HZ    = 25_000_000,
    parameter int         SCCB_FREQ_HZ   = 100_000,
    parameter logic [7:0] DEVICE_ID      = 8'h42,
    parameter int         ROM_ADDR_WIDTH = 8,
    parameter int         INTER_TX_DELAY = 250,
    parameter int         LONG_DELAY     = 250_000
) (
    input  logic                     clk_25,
    input  logic                     reset_n,
    sccb_config_controller_if.master cfg,
    output logic                     sio_c,
    inout  wire                      sio_d
);
    localparam int QTR_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QTR     = QTR_RAW < 1 ? 1 : QTR_RAW;
    localparam int QW      = QTR > 1 ? $clog2(QTR) : 1;
    localparam int DMAX    = LONG_DELAY > INTER_TX_DELAY ? LONG_DELAY : INTER_TX_DELAY;
    localparam int DW      = DMAX > 2 ? $clog2(DMAX) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_LONG, START, BITS, STOP, GAP, DONE} state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    step;
    logic [4:0]    bit_cnt;
    logic [4:0]    nxt_bit;
    logic [DW-1:0] dly;
    logic [26:0]   sreg;
    logic          sio_d_oe;
    logic          sio_d_out;
    logic          tick;

    assign sio_d   = sio_d_oe ? sio_d_out : 1'bz;
    assign tick    = qcnt == QW'(QTR - 1);
    assign nxt_bit = bit_cnt + 5'd1;

    // Sequencer: table walk, quarter-bit timing and registered SCCB line levels
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            qcnt         <= '0;
            step         <= '0;
            bit_cnt      <= '0;
            dly          <= '0;
            sreg         <= '0;
            sio_c        <= 1'b1;
            sio_d_oe     <= 1'b0;
            sio_d_out    <= 1'b0;
            cfg.rom_addr <= '0;
            cfg.busy     <= 1'b0;
            cfg.done     <= 1'b0;
        end else begin
            qcnt <= (state == START || state == BITS || state == STOP) && !tick ? qcnt + QW'(1) : '0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (cfg.start) begin
                        state        <= FETCH;
                        dly          <= '0;
                        cfg.rom_addr <= '0;
                        cfg.busy     <= 1'b1;
                        cfg.done     <= 1'b0;
                    end
                end
                FETCH: begin
                    dly <= dly + DW'(1);
                    if (dly == DW'(1)) begin
                        dly <= '0;
                        if (cfg.rom_data == 16'hFFFF) begin
                            state    <= DONE;
                            cfg.busy <= 1'b0;
                            cfg.done <= 1'b1;
                        end else if (cfg.rom_data == 16'hFFF0) begin
                            state <= WAIT_LONG;
                        end else begin
                            state     <= START;
                            step      <= '0;
                            sreg      <= {DEVICE_ID, 1'b1, cfg.rom_data[15:8], 1'b1, cfg.rom_data[7:0], 1'b1};
                            sio_c     <= 1'b1;
                            sio_d_oe  <= 1'b1;
                            sio_d_out <= 1'b0;
                        end
                    end
                end
                WAIT_LONG, GAP: begin
                    dly <= dly + DW'(1);
                    if (dly == DW'((state == GAP ? INTER_TX_DELAY : LONG_DELAY) - 1)) begin
                        dly          <= '0;
                        state        <= FETCH;
                        cfg.rom_addr <= cfg.rom_addr + ROM_ADDR_WIDTH'(1);
                    end
                end
                START: begin
                    if (tick) begin
                        step <= step + 2'd1;
                        if (step == 2'd1) begin
                            state     <= BITS;
                            step      <= '0;
                            bit_cnt   <= '0;
                            sio_c     <= 1'b0;
                            sio_d_oe  <= 1'b1;
                            sio_d_out <= sreg[26];
                        end
                    end
                end
                BITS: begin
                    if (tick) begin
                        step  <= step + 2'd1;
                        sio_c <= step == 2'd1 || step == 2'd2;
                        if (step == 2'd3) begin
                            if (bit_cnt == 5'd26) begin
                                state     <= STOP;
                                sio_d_oe  <= 1'b1;
                                sio_d_out <= 1'b0;
                            end else begin
                                bit_cnt   <= nxt_bit;
                                sreg      <= sreg << 1;
                                sio_d_oe  <= !(nxt_bit == 5'd8 || nxt_bit == 5'd17 || nxt_bit == 5'd26);
                                sio_d_out <= sreg[25];
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        step      <= step + 2'd1;
                        sio_c     <= step != 2'd0;
                        sio_d_out <= step >= 2'd2;
                        sio_d_oe  <= step != 2'd3;
                        if (step == 2'd3) begin
                            state <= GAP;
                            dly   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_config_controller.sv
// tb_sccb_config_controller: directed tests with an SCCB bus monitor and protocol checker
module tb_sccb_config_controller;
    logic        clk_25 = 1'b0;
    logic        reset_n = 1'b0;
    logic        sio_c;
    wire         sio_d;
    logic [1:0]  sd;
    logic [15:0] rom [256];
    int          errors = 0;
    int          checks = 0;

    int          cyc = 0;
    int          nbits = 0;
    int          frame_start = 0;
    int          last_release = 0;
    int          viol = 0;
    int          frames = 0;
    logic        prev_c = 1'b1;
    logic        prev_l = 1'b1;
    logic        in_frame = 1'b0;
    logic        stop_seen = 1'b0;
    logic        lvl;
    logic [27:0] bits = '0;
    logic [27:0] zmask = '0;
    logic [23:0] writes [$];
    int          spans [$];
    int          gaps [$];

    sccb_config_controller_if #(.ROM_ADDR_WIDTH(8)) cfg ();

    sccb_config_controller #(
        .CLK_FREQ_HZ   (800),
        .SCCB_FREQ_HZ  (100),
        .DEVICE_ID     (8'h42),
        .ROM_ADDR_WIDTH(8),
        .INTER_TX_DELAY(4),
        .LONG_DELAY    (20)
    ) dut (
        .clk_25 (clk_25),
        .reset_n(reset_n),
        .cfg    (cfg),
        .sio_c  (sio_c),
        .sio_d  (sio_d)
    );

    always #5 clk_25 = ~clk_25;

    // Table ROM with one cycle of read latency
    always_ff @(posedge clk_25) cfg.rom_data <= rom[cfg.rom_addr];

    // sio_d as seen on the wire: 0, 1, or 2 when released
    assign sd = dut.sio_d_oe ? {1'b0, sio_d} : 2'd2;

    // Bus monitor: decodes frames and flags any line activity that breaks SCCB rules
    always @(negedge clk_25) begin
        cyc++;
        if (!reset_n) begin
            in_frame = 1'b0;
            stop_seen = 1'b0;
            prev_c = 1'b1;
            prev_l = 1'b1;
        end else begin
            lvl = sd == 2'd2 ? 1'b1 : sd[0];
            if (prev_c && sio_c && lvl != prev_l) begin
                if (!lvl) begin
                    if (in_frame || stop_seen) begin
                        viol++;
                        if (viol <= 10) $display("FAIL protocol_start: cycle %0d start inside frame, required bus idle first", cyc);
                    end
                    in_frame = 1'b1;
                    stop_seen = 1'b0;
                    nbits = 0;
                    bits = '0;
                    zmask = '0;
                    frame_start = cyc;
                    gaps.push_back(cyc - last_release);
                end else if (!in_frame) begin
                    viol++;
                    if (viol <= 10) $display("FAIL protocol_stop: cycle %0d stop outside frame, required a preceding start", cyc);
                end else begin
                    in_frame = 1'b0;
                    stop_seen = 1'b1;
                    frames++;
                    checks++;
                    if (nbits != 28 || zmask !== 28'h0080402) begin
                        errors++;
                        $display("FAIL frame_shape: bits=%0d zmask=%h, required 28 and 0080402", nbits, zmask);
                    end else begin
                        writes.push_back({bits[27:20], bits[18:11], bits[9:2]});
                    end
                end
            end else if (!prev_c && sio_c && in_frame) begin
                bits = {bits[26:0], lvl};
                zmask = {zmask[26:0], sd == 2'd2};
                nbits++;
            end
            if (stop_seen && sd == 2'd2) begin
                stop_seen = 1'b0;
                spans.push_back(cyc - frame_start);
                last_release = cyc;
            end
            if (!in_frame && !stop_seen && (sio_c !== 1'b1 || sd != 2'd2)) begin
                viol++;
                if (viol <= 10) $display("FAIL protocol_idle: cycle %0d sio_c=%b sio_d_code=%0d, required 1 and 2(z)", cyc, sio_c, sd);
            end
            prev_c = sio_c;
            prev_l = lvl;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        writes.delete();
        spans.delete();
        gaps.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk_25);
        cfg.start = 1'b1;
        @(negedge clk_25);
        cfg.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!cfg.done && n < 3000) begin
            @(negedge clk_25);
            n++;
        end
        checks++;
        if (cfg.done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done=%b after 3000 cycles, required 1", name, cfg.done);
        end
    endtask

    task automatic check_one_write(input string name, input logic [23:0] want);
        logic [23:0] w0;
        int          s0;
        w0 = writes.size() > 0 ? writes[0] : 24'h0;
        s0 = spans.size() > 0 ? spans[0] : 0;
        checks++;
        if (writes.size() != 1 || w0 !== want) begin
            errors++;
            $display("FAIL %s_write: count=%0d first=%h, required 1 and %h", name, writes.size(), w0, want);
        end
        checks++;
        if (s0 != 228) begin
            errors++;
            $display("FAIL %s_span: span=%0d cycles, required 228", name, s0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cfg.start = 1'b0;
        tick_n(3);
        checks++;
        if (sio_c !== 1'b1) begin errors++; $display("FAIL reset_sio_c: got %b, required 1", sio_c); end
        checks++;
        if (sd != 2'd2) begin errors++; $display("FAIL reset_sio_d: got code %0d, required 2(z)", sd); end
        checks++;
        if (cfg.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", cfg.busy); end
        checks++;
        if (cfg.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", cfg.done); end
        checks++;
        if (cfg.rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d, required 0", cfg.rom_addr); end
        reset_n = 1'b1;
        tick_n(2);
    endtask

    task automatic test_single_write();
        clear_rom();
        rom[0] = 16'h1280;
        pulse_start();
        checks++;
        if (cfg.busy !== 1'b1) begin errors++; $display("FAIL t2_busy_start: got %b, required 1", cfg.busy); end
        wait_done("t2_done");
        check_one_write("t2", 24'h421280);
        checks++;
        if (cfg.busy !== 1'b0) begin errors++; $display("FAIL t2_busy_end: got %b, required 0", cfg.busy); end
        checks++;
        if (cfg.rom_addr !== 8'd1) begin errors++; $display("FAIL t2_rom_addr: got %0d, required 1", cfg.rom_addr); end
    endtask

    task automatic test_delay_entry();
        logic [23:0] w0;
        logic [23:0] w1;
        int          g1;
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1101;
        pulse_start();
        wait_done("t3_done");
        w0 = writes.size() > 0 ? writes[0] : 24'h0;
        w1 = writes.size() > 1 ? writes[1] : 24'h0;
        g1 = gaps.size() > 1 ? gaps[1] : 0;
        checks++;
        if (writes.size() != 2 || w0 !== 24'h421280 || w1 !== 24'h421101) begin
            errors++;
            $display("FAIL t3_writes: count=%0d w0=%h w1=%h, required 2 421280 421101", writes.size(), w0, w1);
        end
        checks++;
        if (g1 < 20 || g1 > 40) begin errors++; $display("FAIL t3_gap: idle=%0d cycles, required 20..40", g1); end
        checks++;
        if (cfg.rom_addr !== 8'd3) begin errors++; $display("FAIL t3_rom_addr: got %0d, required 3", cfg.rom_addr); end
    endtask

    task automatic test_start_ignored();
        clear_rom();
        rom[0] = 16'hAB55;
        pulse_start();
        tick_n(60);
        pulse_start();
        wait_done("t4_done");
        check_one_write("t4", 24'h42AB55);
        checks++;
        if (cfg.rom_addr !== 8'd1) begin errors++; $display("FAIL t4_rom_addr: got %0d, required 1", cfg.rom_addr); end
    endtask

    task automatic test_back_to_back();
        writes.delete();
        spans.delete();
        pulse_start();
        checks++;
        if (cfg.done !== 1'b0 || cfg.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: done=%b busy=%b, required 0 1", cfg.done, cfg.busy);
        end
        wait_done("b2b_done");
        check_one_write("b2b", 24'h42AB55);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_rom();
        rom[0] = 16'h3A04;
        pulse_start();
        tick_n(160);
        while (!(sio_c == 1'b0 && sd != 2'd2) && n < 20) begin
            @(negedge clk_25);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (sio_c !== 1'b1 || sd != 2'd2) begin
            errors++;
            $display("FAIL t5_release: sio_c=%b sio_d_code=%0d, required 1 and 2(z)", sio_c, sd);
        end
        checks++;
        if (cfg.busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b, required 0", cfg.busy); end
        tick_n(3);
        reset_n = 1'b1;
        tick_n(2);
        checks++;
        if (writes.size() != 0) begin errors++; $display("FAIL t5_aborted: writes=%0d, required 0", writes.size()); end
        pulse_start();
        wait_done("t5_done");
        check_one_write("t5", 24'h423A04);
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL protocol_total: violations=%0d, required 0", viol); end
        checks++;
        if (frames != 6) begin errors++; $display("FAIL frame_total: frames=%0d, required 6", frames); end
    endtask

    initial begin
        cfg.start = 1'b0;
        clear_rom();
        test_reset();
        test_single_write();
        test_delay_entry();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
